// File: rtl/ucounter_8.sv
// ucounter_8: up/down counter with async clear/preset, sync load, count enable and wrap/stop limit modes.
// Optional terminal-count output tc is enabled by defining UCOUNTER8_TERMCNT_EN.
module ucounter_8 #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             _areset,
   input  logic             _aset,
   input  logic             _load,
   input  logic [WIDTH-1:0] preld_val,
   input  logic             _updown,
   input  logic             _wrapstop,
   input  logic             _carry_in,
   output logic             overflow,
`ifdef UCOUNTER8_TERMCNT_EN
   output logic             tc,
`endif
   output logic [WIDTH-1:0] dcount
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic             ovf_q;
   logic [WIDTH-1:0] count_d;
   logic             ovf_d;
   logic             at_max;
   logic             at_zero;
   logic             crossing;

   assign at_max   = (count_q == MAX_VAL);
   assign at_zero  = (count_q == ZERO);
   // An enabled step that would leave the [0, MAX_VAL] range.
   assign crossing = _updown ? at_max : at_zero;

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (_load) begin
         count_d = preld_val;
      end else if (_carry_in) begin
         if (crossing) begin
            ovf_d = 1'b1;
            // Stop mode leaves count_d at the limit; wrap mode jumps to the opposite limit.
            if (_wrapstop) begin
               count_d = _updown ? ZERO : MAX_VAL;
            end
         end else begin
            count_d = _updown ? (count_q + ONE) : (count_q - ONE);
         end
      end
   end

   always_ff @(posedge clk or negedge _areset or posedge _aset) begin
      if (!_areset) begin
         count_q <= ZERO;
         ovf_q   <= 1'b0;
      end else if (_aset) begin
         count_q <= MAX_VAL;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign dcount   = count_q;
   assign overflow = ovf_q;

`ifdef UCOUNTER8_TERMCNT_EN
   // Terminal count looks at the register only, so it ignores _carry_in and _wrapstop.
   assign tc = _updown ? at_max : at_zero;
`endif

endmodule

// File: tb/tb_ucounter_8.sv
// Directed self-checking bench for ucounter_8: reset, load, wrap/stop limits, down boundary, priority.
module tb_ucounter_8;

   logic       clk;
   logic       _areset;
   logic       _aset;
   logic       _load;
   logic [7:0] preld_val;
   logic       _updown;
   logic       _wrapstop;
   logic       _carry_in;
   logic       overflow;
   logic [7:0] dcount;
`ifdef UCOUNTER8_TERMCNT_EN
   logic       tc;
`endif

   int errors = 0;
   int checks = 0;

   ucounter_8 #(.WIDTH(8), .MAX_VAL(8'hFF)) dut (
      .clk       (clk),
      ._areset   (_areset),
      ._aset     (_aset),
      ._load     (_load),
      .preld_val (preld_val),
      ._updown   (_updown),
      ._wrapstop (_wrapstop),
      ._carry_in (_carry_in),
      .overflow  (overflow),
`ifdef UCOUNTER8_TERMCNT_EN
      .tc        (tc),
`endif
      .dcount    (dcount)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one rising edge, then settle 1 ns before inputs change or outputs are read
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      _areset = 1'b0; _aset = 1'b0; _load = 1'b0; preld_val = 8'h00;
      _updown = 1'b1; _wrapstop = 1'b1; _carry_in = 1'b1;
      #2;
      checks++;
      if (dcount !== 8'h00 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: got dcount=%h ovf=%b want 00/0", dcount, overflow);
      end
      step();
      _areset = 1'b1;
      step(); step(); step();
      // mid-cycle assertion with counting enabled
      #2 _areset = 1'b0;
      #1;
      checks++;
      if (dcount !== 8'h00 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got dcount=%h ovf=%b want 00/0", dcount, overflow);
      end
      #1 _areset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (dcount !== 8'(i) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_up[%0d]: got dcount=%h ovf=%b want %h/0", i, dcount, overflow, 8'(i));
         end
      end
   endtask

   task automatic test_load_updown();
      logic [7:0] exp_up [5];
      logic [7:0] exp_dn [5];
      exp_up = '{8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA};
      exp_dn = '{8'hC9, 8'hC8, 8'hC7, 8'hC6, 8'hC5};
      preld_val = 8'hC5; _load = 1'b1; _updown = 1'b0;
      step();
      _load = 1'b0; _updown = 1'b1;
      checks++;
      if (dcount !== 8'hC5 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL load: got dcount=%h ovf=%b want c5/0", dcount, overflow);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (dcount !== exp_up[i]) begin
            errors++;
            $display("FAIL load_up[%0d]: got %h want %h", i, dcount, exp_up[i]);
         end
      end
      _updown = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (dcount !== exp_dn[i]) begin
            errors++;
            $display("FAIL load_down[%0d]: got %h want %h", i, dcount, exp_dn[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_cnt [5];
      logic       exp_ovf [5];
      exp_cnt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      exp_ovf = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      _wrapstop = 1'b1; _updown = 1'b1; _carry_in = 1'b1;
      _aset = 1'b1;
      #1;
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b0) begin
         errors++;
         $display("FAIL wrap_aset: got dcount=%h ovf=%b want ff/0", dcount, overflow);
      end
      #1 _aset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (dcount !== exp_cnt[i] || overflow !== exp_ovf[i]) begin
            errors++;
            $display("FAIL wrap_up[%0d]: got dcount=%h ovf=%b want %h/%b", i, dcount, overflow, exp_cnt[i], exp_ovf[i]);
         end
      end
   endtask

   task automatic test_stop();
      _wrapstop = 1'b0; _updown = 1'b1; _carry_in = 1'b1;
      _aset = 1'b1;
      #1 _aset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (dcount !== 8'hFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL stop_up[%0d]: got dcount=%h ovf=%b want ff/1", i, dcount, overflow);
         end
      end
`ifdef UCOUNTER8_TERMCNT_EN
      checks++;
      if (tc !== 1'b1) begin
         errors++;
         $display("FAIL tc_up_at_ff: got %b want 1", tc);
      end
`endif
      _carry_in = 1'b0;
      step();
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b0) begin
         errors++;
         $display("FAIL stop_disable: got dcount=%h ovf=%b want ff/0", dcount, overflow);
      end
   endtask

   task automatic test_down_boundary();
      _areset = 1'b0;
      #1 _areset = 1'b1;
      _updown = 1'b0; _wrapstop = 1'b1; _carry_in = 1'b1;
`ifdef UCOUNTER8_TERMCNT_EN
      #1;
      checks++;
      if (tc !== 1'b1) begin
         errors++;
         $display("FAIL tc_down_at_zero: got %b want 1", tc);
      end
`endif
      step();
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap: got dcount=%h ovf=%b want ff/1", dcount, overflow);
      end
      step();
      checks++;
      if (dcount !== 8'hFE || overflow !== 1'b0) begin
         errors++;
         $display("FAIL down_after_wrap: got dcount=%h ovf=%b want fe/0", dcount, overflow);
      end
      _areset = 1'b0;
      #1 _areset = 1'b1;
      _wrapstop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (dcount !== 8'h00 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL down_stop[%0d]: got dcount=%h ovf=%b want 00/1", i, dcount, overflow);
         end
      end
      _updown = 1'b1;
      step();
      checks++;
      if (dcount !== 8'h01 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL dir_change: got dcount=%h ovf=%b want 01/0", dcount, overflow);
      end
   endtask

   task automatic test_priority_hold();
      preld_val = 8'h5A;
      _areset = 1'b0; _aset = 1'b1; _load = 1'b1;
      #1;
      checks++;
      if (dcount !== 8'h00 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL prio_reset: got dcount=%h ovf=%b want 00/0", dcount, overflow);
      end
      _areset = 1'b1;
      step();
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b0) begin
         errors++;
         $display("FAIL prio_aset_over_load: got dcount=%h ovf=%b want ff/0", dcount, overflow);
      end
      _aset = 1'b0; _load = 1'b0; _carry_in = 1'b0; _updown = 1'b0; _wrapstop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (dcount !== 8'hFF || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got dcount=%h ovf=%b want ff/0", i, dcount, overflow);
         end
      end
   endtask

   task automatic test_back_to_back();
      // consecutive loads override counting; load also clears a pending overflow
      _wrapstop = 1'b0; _updown = 1'b1; _carry_in = 1'b1;
      preld_val = 8'h33; _load = 1'b1;
      step();
      checks++;
      if (dcount !== 8'h33 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load0: got dcount=%h ovf=%b want 33/0", dcount, overflow);
      end
      preld_val = 8'hFF;
      step();
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load1: got dcount=%h ovf=%b want ff/0", dcount, overflow);
      end
      _load = 1'b0;
      step();
      checks++;
      if (dcount !== 8'hFF || overflow !== 1'b1) begin
         errors++;
         $display("FAIL b2b_stop_after_load: got dcount=%h ovf=%b want ff/1", dcount, overflow);
      end
      preld_val = 8'h10; _load = 1'b1;
      step();
      _load = 1'b0;
      checks++;
      if (dcount !== 8'h10 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load_clears_ovf: got dcount=%h ovf=%b want 10/0", dcount, overflow);
      end
      step();
      checks++;
      if (dcount !== 8'h11 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_count_after_load: got dcount=%h ovf=%b want 11/0", dcount, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_load_updown();
      test_wrap();
      test_stop();
      test_down_boundary();
      test_priority_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ucounter_8.md
Name: ucounter_8

Overview:
8-bit up/down counter with asynchronous clear, asynchronous preset to all-ones, synchronous parallel load, count enable (carry-in) and selectable wrap-around or stop-at-limit behaviour. The overflow flag reports boundary crossings. It is a general-purpose counter leaf cell used by timer and sequencing logic.

Parameters:
WIDTH, 8, counter width in bits; all widths and limits below scale with it.
MAX_VAL, 2**WIDTH-1 (8'hFF), upper count limit and asynchronous preset value.

Ports:
clk  input  1  rising-edge clock.
_areset  input  1  asynchronous reset, active-low; clears dcount and overflow.
_aset  input  1  asynchronous preset, active-high; forces dcount=MAX_VAL.
_load  input  1  synchronous load, active-high; dcount<=preld_val.
preld_val  input  WIDTH  parallel preload value.
_updown  input  1  direction: 1 = count up, 0 = count down.
_wrapstop  input  1  limit mode: 1 = wrap around, 0 = stop (saturate) at limit.
_carry_in  input  1  count enable: 1 = step by one this cycle, 0 = hold.
overflow  output  1  registered boundary-crossing flag.
dcount  output  WIDTH  registered count value.

Behaviour:
- One clock domain (clk, rising edge). Reset is asynchronous and active-low (_areset); all state is cleared immediately on assertion, with no clock required.
- Priority, highest first: _areset low -> dcount=0, overflow=0 | _aset high -> dcount=MAX_VAL, overflow=0 | _load -> dcount<=preld_val, overflow<=0 | count | hold.
- _areset and _aset act asynchronously. After release, counting resumes on the first rising clk edge on which the signal is inactive.
- Load is synchronous and has a latency of 1 edge. It ignores _carry_in and _updown.
- Count step, on an edge with _carry_in=1 and no higher-priority action: up -> dcount+1; down -> dcount-1. With _carry_in=0: dcount holds and overflow<=0.
- Wrap mode (_wrapstop=1):
  - Up from MAX_VAL gives 0.
  - Down from 0 gives MAX_VAL.
  - overflow<=1 for exactly the cycle following the wrapping edge. Otherwise overflow<=0.
- Stop mode (_wrapstop=0):
  - Up at MAX_VAL and down at 0 both leave dcount unchanged.
  - overflow<=1 on every enabled edge that attempts to cross the limit, so it stays high while held at the limit with _carry_in=1.
  - Non-crossing steps give overflow<=0.
- Changing _updown or _wrapstop mid-count takes effect on the next edge. The counter has no internal state beyond dcount and overflow.
- Both outputs come directly from flops. No combinational path exists from inputs to outputs, except through the asynchronous clear/preset.
- Power-up state is undefined until _areset is asserted.

Optional Feature:
Macro UCOUNTER8_TERMCNT_EN.
- Defined: adds output port tc (1 bit, combinational from the dcount register).
  - tc=1 when _updown=1 and dcount==MAX_VAL.
  - tc=1 when _updown=0 and dcount==0.
  - tc=0 otherwise. It is unaffected by _wrapstop and _carry_in.
- Undefined: tc port and its logic are absent. All other behaviour is identical.

Test Plan:
- Async reset: set _areset=0 mid-cycle with _carry_in=1 -> dcount=0 and overflow=0 immediately. Release, count up 5 edges -> dcount 1,2,3,4,5.
- Load then up/down: preld_val=8'hC5, pulse _load for 1 edge -> dcount=C5. Up 5 edges -> C6..CA. Set _updown=0, 5 edges -> C9..C5.
- Wrap: set _wrapstop=1, pulse _aset -> dcount=FF asynchronously. Up 5 edges -> 00,01,02,03,04. overflow=1 only in the cycle after FF->00.
- Stop: set _wrapstop=0, pulse _aset -> FF. Up 5 edges -> dcount stays FF, overflow=1 throughout. Drop _carry_in -> overflow=0 next edge, dcount=FF.
- Down boundary: after reset, _updown=0. With _wrapstop=1, one edge -> FF and overflow pulses. With _wrapstop=0 from 0 -> stays 0 and overflow=1.
- Priority/hold: _areset=0 with _aset=1 and _load=1 -> dcount=0. Then _aset=1 with _load=1 -> FF. Then _carry_in=0 -> dcount holds over 4 edges. With UCOUNTER8_TERMCNT_EN defined, tc=1 at FF counting up.
